iob_uart2iob: RTL and testbench
===============================

Name: iob_uart2iob

Overview:
- UART-controlled IOb-native bus initiator (debug/boot bridge).
- Receives 8N1 command frames on a serial line and issues single IOb read or write transactions.
- Returns the result serially.
- Sits on the host-facing pins of a SoC; drives the same IOb slave bus that UART-style peripherals respond on.

Parameters:
- ADDR_W, 32, IOb address width driven; the low ADDR_W bits of the 32-bit received address are used (ADDR_W <= 32).
- DIV_W, 16, width of bit_duration_i.
- TIMEOUT_CYCLES, 1024, bus wait limit; used only with the optional feature.

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  reset, asynchronous, active-high
- bit_duration_i  in  DIV_W  clk_i cycles per serial bit; static during operation; value < 4 is unsupported
- rxd_i  in  1  serial input, idle high, asynchronous to clk_i
- txd_o  out  1  serial output, idle high
- iob_avalid_o  out  1  request valid
- iob_addr_o  out  ADDR_W  request address
- iob_wdata_o  out  32  write data
- iob_wstrb_o  out  4  write strobes; 0 means read
- iob_ready_i  in  1  request accepted this cycle
- iob_rvalid_i  in  1  read data valid
- iob_rdata_i  in  32  read data
- busy_o  out  1  high from first command byte accepted until last response stop bit sent
- err_o  out  1  one-cycle pulse on framing error, bad command or timeout

Behaviour:
- Reset values: txd_o=1; all other outputs 0. All FSMs go to IDLE. Reset mid-frame aborts immediately; any partially sent byte is truncated with txd_o forced to 1.
- rxd_i input: passes through a 2-FF synchronizer.
- RX start detection: a synchronized falling edge starts reception.
- RX sampling: start bit sampled at bit_duration_i/2 (floor); if low, 8 data bits (LSB first) then the stop bit are sampled every bit_duration_i.
- RX start-bit glitch: if the start-bit sample is high, reception is abandoned silently.
- RX framing error: stop bit = 0 drops the byte, pulses err_o and returns the command FSM to IDLE.
- TX: 8N1, LSB first, each bit exactly bit_duration_i cycles; bytes are sent back-to-back with no idle gap.
- Command FSM states: IDLE, ADDR (4 bytes, little-endian), WDATA (4 bytes, little-endian), BUS_REQ, BUS_RDATA, RESP, NAK.
- IDLE transitions:
  - 0x57 ('W'): go to ADDR, write mode.
  - 0x52 ('R'): go to ADDR, read mode.
  - Any other byte: go to NAK and pulse err_o.
- ADDR transitions: after byte 4, write mode goes to WDATA; read mode goes to BUS_REQ.
- WDATA transition: after byte 4, go to BUS_REQ.
- BUS_REQ:
  - Signals: iob_avalid_o=1 with address/data/strobe stable; wstrb=4'hF for write, 4'h0 for read.
  - iob_avalid_o is held until a cycle with iob_ready_i=1, then deasserted the next cycle.
  - Write: on ready, go to RESP with response byte 0x06.
  - Read: go to BUS_RDATA. If iob_rvalid_i arrives in the same cycle as iob_ready_i, capture rdata in that cycle and go straight to RESP.
- BUS_RDATA: capture iob_rdata_i on the first iob_rvalid_i, then go to RESP and send 4 bytes, little-endian.
- NAK: send 0x15, then go to IDLE.
- Bytes arriving while not in IDLE/ADDR/WDATA are discarded, with no error.
- busy_o is 0 only in IDLE after the final stop bit.

Optional Feature:
- Macro: IOB_UART2IOB_TIMEOUT_EN.
- When defined: a counter runs in BUS_REQ and BUS_RDATA. On reaching TIMEOUT_CYCLES without ready (or rvalid, respectively):
  - drop avalid;
  - pulse err_o;
  - go to NAK.
- A late rvalid after a timeout is ignored.
- When undefined: no counter exists and the bridge waits indefinitely.

Decomposition:
- Shared package iob_uart2iob_pkg holds:
  - command byte constants CMD_WR=0x57, CMD_RD=0x52;
  - response constants RSP_ACK=0x06, RSP_NAK=0x15;
  - the command FSM state enum;
  - the byte-counter width (2 bits).
- One natural sub-module: iob_uart2iob_phy.
  - Contents: 8N1 byte RX (synchronizer, sampler, framing error flag) and TX (tx_valid/tx_ready byte handshake, serializer).
  - Shared baud counters: none; RX and TX are independent.

Test Plan:
- Write: bit_duration_i=10; send 57 10 00 00 00 EF BE AD DE.
  - Expected: one avalid with addr=0x10, wdata=0xDEADBEEF, wstrb=F.
  - With ready delayed 3 cycles: avalid is held 4 cycles; then byte 06 is received.
- Read: send 52 20 00 00 00; slave asserts ready and rvalid in the same cycle with rdata=0x12345678.
  - Expected: wstrb=0, then bytes 78 56 34 12 back-to-back.
- Bad command: send 41.
  - Expected: err_o pulses once, response 15, no avalid; busy_o returns to 0.
- Framing error: send 57 with stop bit=0, then a valid read frame.
  - Expected: err_o pulse; the subsequent read completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=16): read with ready never asserted.
  - Expected: avalid drops after 16 cycles, err_o pulse, response 15.
- Reset mid-operation: assert arst_i during the second response byte.
  - Expected: txd_o=1 and all outputs 0 immediately; a new write after release succeeds.

Source files
------------

// File: rtl/iob_uart2iob_pkg.sv
// iob_uart2iob_pkg: command/response bytes, command FSM states and byte-counter width shared by the bridge
package iob_uart2iob_pkg;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;
    localparam int CNT_W = 2;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_REQ, BUS_RDATA, RESP, NAK} cmd_state_t;
endpackage

// File: rtl/iob_uart2iob_phy.sv
// iob_uart2iob_phy: independent 8N1 byte receiver and transmitter
// Ports: clk_i/arst_i (async active-high reset), bit_duration_i (cycles per bit),
//   rxd_i -> rx_data/rx_valid/rx_err (one-cycle strobes at the stop-bit sample),
//   tx_data/tx_valid/tx_ready byte handshake -> txd_o, tx_busy while a frame is on the line.
module iob_uart2iob_phy #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [DIV_W-1:0] bit_duration_i,
    input  logic             rxd_i,
    output logic             txd_o,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_err,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_busy
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t        rx_state, rx_state_n;
    logic [2:0]       rx_sync;
    logic [DIV_W-1:0] rx_cnt;
    logic [2:0]       rx_bits;
    logic [7:0]       rx_shift;
    logic             rx_bit, rx_fall, rx_tick;
    logic [9:0]       tx_shift;
    logic [3:0]       tx_bits;
    logic [DIV_W-1:0] tx_cnt;
    logic             tx_tick, tx_last, tx_load;
    // [0],[1] form the synchronizer; [2] is the previous synchronized level for edge detection
    assign rx_bit  = rx_sync[1];
    assign rx_fall = rx_sync[2] & ~rx_sync[1];
    assign rx_tick = rx_cnt == '0;
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) rx_state <= RX_IDLE;
        else rx_state <= rx_state_n;
    end
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
            RX_START: if (rx_tick) rx_state_n = rx_bit ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end
    // the half-bit delay is preloaded while idle so the start bit is sampled mid-bit
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rx_sync  <= 3'b111;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[1:0], rxd_i};
            rx_cnt   <= rx_state == RX_IDLE ? (bit_duration_i >> 1) - ONE :
                        rx_tick ? bit_duration_i - ONE : rx_cnt - ONE;
            rx_bits  <= rx_state == RX_DATA ? rx_bits + 3'(rx_tick) : 3'd0;
            rx_shift <= (rx_state == RX_DATA && rx_tick) ? {rx_bit, rx_shift[7:1]} : rx_shift;
        end
    end
    assign rx_data  = rx_shift;
    assign rx_valid = rx_state == RX_STOP && rx_tick && rx_bit;
    assign rx_err   = rx_state == RX_STOP && rx_tick && !rx_bit;
    // a new byte is accepted on the last cycle of the stop bit, so frames run back-to-back
    assign tx_tick  = tx_cnt == '0;
    assign tx_last  = tx_busy && tx_tick && tx_bits == 4'd0;
    assign tx_ready = !tx_busy || tx_last;
    assign tx_load  = tx_valid && tx_ready;
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
        end else begin
            tx_busy  <= tx_load || (tx_busy && !tx_last);
            tx_cnt   <= (tx_load || tx_tick) ? bit_duration_i - ONE : tx_cnt - ONE;
            tx_bits  <= tx_load ? 4'd9 : tx_bits - 4'(tx_busy && tx_tick);
            tx_shift <= tx_load ? {1'b1, tx_data, 1'b0} :
                        (tx_busy && tx_tick) ? {1'b1, tx_shift[9:1]} : tx_shift;
        end
    end
    assign txd_o = !tx_busy || tx_shift[0];
endmodule

// File: rtl/iob_uart2iob.sv
// iob_uart2iob: UART-commanded single-transaction IOb bus initiator (debug/boot bridge)
// Ports: clk_i, arst_i (async active-high), bit_duration_i, rxd_i/txd_o serial pins,
//   iob_avalid_o/iob_addr_o/iob_wdata_o/iob_wstrb_o requests, iob_ready_i/iob_rvalid_i/iob_rdata_i responses,
//   busy_o while a command or its response is in flight, err_o one-cycle error pulse.
// Option: define IOB_UART2IOB_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES with a NAK.
module iob_uart2iob #(
    parameter int ADDR_W         = 32,
    parameter int DIV_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DIV_W-1:0]  bit_duration_i,
    input  logic              rxd_i,
    output logic              txd_o,
    output logic              iob_avalid_o,
    output logic [ADDR_W-1:0] iob_addr_o,
    output logic [31:0]       iob_wdata_o,
    output logic [3:0]        iob_wstrb_o,
    input  logic              iob_ready_i,
    input  logic              iob_rvalid_i,
    input  logic [31:0]       iob_rdata_i,
    output logic              busy_o,
    output logic              err_o
);
    import iob_uart2iob_pkg::*;
    cmd_state_t       state, state_n;
    logic             wr, err, err_n, tmo_hit;
    logic [CNT_W-1:0] bcnt;
    logic [31:0]      addr, wdata, rdata;
    logic [7:0]       rx_data, tx_data;
    logic             rx_valid, rx_err, tx_valid, tx_ready, tx_busy, rx_open;
    iob_uart2iob_phy #(.DIV_W(DIV_W)) phy (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .bit_duration_i(bit_duration_i),
        .rxd_i         (rxd_i),
        .txd_o         (txd_o),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_err        (rx_err),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_busy       (tx_busy)
    );
    // received bytes (and framing errors) only matter while a command is being collected
    assign rx_open = state inside {IDLE, ADDR, WDATA};
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n  = state;
        err_n    = rx_open && rx_err;
        tx_valid = 1'b0;
        tx_data  = rdata[7:0];
        case (state)
            IDLE: if (rx_valid) begin
                state_n = (rx_data == CMD_WR || rx_data == CMD_RD) ? ADDR : NAK;
                err_n   = state_n == NAK;
            end
            ADDR:      state_n = rx_err ? IDLE : (rx_valid && &bcnt) ? (wr ? WDATA : BUS_REQ) : ADDR;
            WDATA:     state_n = rx_err ? IDLE : (rx_valid && &bcnt) ? BUS_REQ : WDATA;
            BUS_REQ: begin
                state_n = iob_ready_i ? ((wr || iob_rvalid_i) ? RESP : BUS_RDATA) : tmo_hit ? NAK : BUS_REQ;
                err_n   = !iob_ready_i && tmo_hit;
            end
            BUS_RDATA: begin
                state_n = iob_rvalid_i ? RESP : tmo_hit ? NAK : BUS_RDATA;
                err_n   = !iob_rvalid_i && tmo_hit;
            end
            RESP: begin
                tx_valid = 1'b1;
                tx_data  = wr ? RSP_ACK : rdata[7:0];
                state_n  = (tx_ready && (wr || &bcnt)) ? IDLE : RESP;
            end
            NAK: begin
                tx_valid = 1'b1;
                tx_data  = RSP_NAK;
                state_n  = tx_ready ? IDLE : NAK;
            end
            default: state_n = IDLE;
        endcase
    end
    // bcnt counts bytes within a state and restarts on every state change
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr    <= 1'b0;
            err   <= 1'b0;
            bcnt  <= '0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            err  <= err_n;
            bcnt <= state_n != state ? '0 :
                    bcnt + CNT_W'((rx_valid && (state == ADDR || state == WDATA)) || (tx_valid && tx_ready));
            if (state == IDLE && rx_valid) wr <= rx_data == CMD_WR;
            if (state == ADDR && rx_valid) addr <= {rx_data, addr[31:8]};
            if (state == WDATA && rx_valid) wdata <= {rx_data, wdata[31:8]};
            if (!wr && iob_rvalid_i && ((state == BUS_REQ && iob_ready_i) || state == BUS_RDATA)) rdata <= iob_rdata_i;
            else if (state == RESP && tx_ready) rdata <= rdata >> 8;
        end
    end
`ifdef IOB_UART2IOB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo;
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) tmo <= '0;
        else tmo <= (state_n == state && (state == BUS_REQ || state == BUS_RDATA)) ? tmo + TMO_W'(1) : '0;
    end
    assign tmo_hit = tmo == TMO_W'(TIMEOUT_CYCLES - 1);
`else
    // no timeout: the bridge waits on the bus indefinitely
    assign tmo_hit = TIMEOUT_CYCLES < 0;
`endif
    assign iob_avalid_o = state == BUS_REQ;
    assign iob_addr_o   = addr[ADDR_W-1:0];
    assign iob_wdata_o  = wdata;
    assign iob_wstrb_o  = {4{wr && state == BUS_REQ}};
    assign busy_o       = state != IDLE || tx_busy;
    assign err_o        = err;
endmodule

// File: tb/tb_iob_uart2iob.sv
// tb_iob_uart2iob: scoreboard bench for the UART-to-IOb bridge
module tb_iob_uart2iob;
    localparam int BD = 10;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          hold;
        bit          to;
    } bus_t;
    logic        clk = 1'b0, arst_i = 1'b1, rxd_i = 1'b1;
    logic        iob_ready_i = 1'b0, iob_rvalid_i = 1'b0;
    logic [31:0] iob_rdata_i = '0;
    logic        txd_o, iob_avalid_o, busy_o, err_o;
    logic [31:0] iob_addr_o, iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic [7:0]  exp_tx[$];
    bus_t        exp_bus[$];
    int          n_chk = 0, n_pass = 0, err_cnt = 0, exp_err = 0;
    int          ready_dly = 0, rv_dly = 0, hold = 0, rv_cnt = 0;
    bit          slave_en = 1'b1, acc = 1'b0;
    logic [31:0] rd_val = '0;
    logic [7:0]  tx_b;
    logic        tx_ab, tx_stop;

    iob_uart2iob #(.ADDR_W(32), .DIV_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .arst_i(arst_i), .bit_duration_i(16'(BD)), .rxd_i(rxd_i), .txd_o(txd_o),
        .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i(iob_rdata_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd_i = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_i = b[i];
            repeat (BD) @(negedge clk);
        end
        rxd_i = stop;
        repeat (BD) @(negedge clk);
        rxd_i = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic do_read(input logic [31:0] a);
        send_byte(8'h52, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    endtask

    task automatic wait_idle(input string n);
        int k;
        k = 0;
        while ((busy_o || exp_tx.size() != 0 || exp_bus.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({n, "_done"}, {31'b0, k < 3000}, 32'd1);
        repeat (2) @(negedge clk);
        chk({n, "_err"}, err_cnt, exp_err);
    endtask

    task automatic bus_check(input bit to);
        bus_t e;
        if (exp_bus.size() == 0) begin
            n_chk++;
            $display("FAIL bus_unexpected: got addr %h wstrb %h expected no request", iob_addr_o, iob_wstrb_o);
        end else begin
            e = exp_bus.pop_front();
            chk("bus_addr", iob_addr_o, e.addr);
            chk("bus_wstrb", {28'b0, iob_wstrb_o}, {28'b0, e.wstrb});
            chk("bus_hold", hold, e.hold);
            chk("bus_timeout", {31'b0, to}, {31'b0, e.to});
            if (e.wstrb != 4'h0) chk("bus_wdata", iob_wdata_o, e.wdata);
        end
    endtask

    // slave model plus request checker
    initial begin : slave
        forever begin
            @(negedge clk);
            iob_ready_i  = 1'b0;
            iob_rvalid_i = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    iob_rvalid_i = 1'b1;
                    iob_rdata_i  = rd_val;
                end
            end
            if (acc) begin
                chk("avalid_drop", {31'b0, iob_avalid_o}, 32'd0);
                acc = 1'b0;
            end else if (iob_avalid_o) begin
                hold++;
                if (slave_en && hold == ready_dly + 1) begin
                    iob_ready_i = 1'b1;
                    acc = 1'b1;
                    if (iob_wstrb_o == 4'h0) begin
                        if (rv_dly == 0) begin
                            iob_rvalid_i = 1'b1;
                            iob_rdata_i  = rd_val;
                        end else rv_cnt = rv_dly;
                    end
                    bus_check(1'b0);
                    hold = 0;
                end
            end else if (hold > 0) begin
                bus_check(1'b1);
                hold = 0;
            end
        end
    end

    // serial response monitor
    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (!arst_i && txd_o == 1'b0) begin
                tx_ab = 1'b0;
                repeat (BD / 2) begin @(negedge clk); tx_ab |= arst_i; end
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) begin @(negedge clk); tx_ab |= arst_i; end
                    tx_b[i] = txd_o;
                end
                repeat (BD) begin @(negedge clk); tx_ab |= arst_i; end
                tx_stop = txd_o;
                if (!tx_ab) begin
                    if (exp_tx.size() == 0) begin
                        n_chk++;
                        $display("FAIL tx_unexpected: got byte %h expected none", tx_b);
                    end else begin
                        chk("tx_byte", {24'b0, tx_b}, {24'b0, exp_tx.pop_front()});
                        chk("tx_stop", {31'b0, tx_stop}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin : err_mon
        forever begin
            @(negedge clk);
            if (err_o) err_cnt++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish, %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'b0, txd_o}, 32'd1);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_avalid", {31'b0, iob_avalid_o}, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_addr", iob_addr_o, 32'd0);
        chk("rst_wstrb", {28'b0, iob_wstrb_o}, 32'd0);
        arst_i = 1'b0;
        repeat (5) @(negedge clk);
        // write with ready delayed by 3 cycles
        ready_dly = 3;
        exp_bus.push_back('{32'h10, 32'hDEADBEEF, 4'hF, 4, 1'b0});
        exp_tx.push_back(8'h06);
        do_write(32'h10, 32'hDEADBEEF);
        chk("wr_busy", {31'b0, busy_o}, 32'd1);
        wait_idle("wr");
        // read with ready and rvalid together
        ready_dly = 0;
        rv_dly = 0;
        rd_val = 32'h12345678;
        exp_bus.push_back('{32'h20, 32'h0, 4'h0, 1, 1'b0});
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56); exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        do_read(32'h20);
        wait_idle("rd");
        // bad command
        exp_tx.push_back(8'h15);
        exp_err++;
        send_byte(8'h41, 1'b1);
        wait_idle("badcmd");
        chk("badcmd_busy", {31'b0, busy_o}, 32'd0);
        // start-bit glitch is ignored
        rxd_i = 1'b0;
        repeat (2) @(negedge clk);
        rxd_i = 1'b1;
        repeat (2 * BD) @(negedge clk);
        chk("glitch_busy", {31'b0, busy_o}, 32'd0);
        chk("glitch_err", err_cnt, exp_err);
        // framing error, then a read with rvalid two cycles after ready
        exp_err++;
        send_byte(8'h57, 1'b0);
        repeat (BD) @(negedge clk);
        chk("frm_err", err_cnt, exp_err);
        chk("frm_busy", {31'b0, busy_o}, 32'd0);
        rv_dly = 2;
        rd_val = 32'hCAFEF00D;
        exp_bus.push_back('{32'h40, 32'h0, 4'h0, 1, 1'b0});
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'hF0); exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
        do_read(32'h40);
        wait_idle("frm_rd");
`ifdef IOB_UART2IOB_TIMEOUT_EN
        slave_en = 1'b0;
        exp_bus.push_back('{32'h50, 32'h0, 4'h0, 16, 1'b1});
        exp_tx.push_back(8'h15);
        exp_err++;
        do_read(32'h50);
        wait_idle("tmo");
        slave_en = 1'b1;
`endif
        // reset during the start bit of the second response byte
        rv_dly = 0;
        rd_val = 32'hA1B2C3D4;
        exp_bus.push_back('{32'h30, 32'h0, 4'h0, 1, 1'b0});
        exp_tx.push_back(8'hD4); exp_tx.push_back(8'hC3); exp_tx.push_back(8'hB2); exp_tx.push_back(8'hA1);
        do_read(32'h30);
        k = 0;
        while (exp_tx.size() > 3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_first_byte", {31'b0, k < 2000}, 32'd1);
        repeat (7) @(negedge clk);
        chk("mid_txd_low", {31'b0, txd_o}, 32'd0);
        chk("mid_busy", {31'b0, busy_o}, 32'd1);
        arst_i = 1'b1;
        #1;
        chk("mid_rst_txd", {31'b0, txd_o}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        chk("mid_rst_avalid", {31'b0, iob_avalid_o}, 32'd0);
        chk("mid_rst_err", {31'b0, err_o}, 32'd0);
        chk("mid_rst_wdata", iob_wdata_o, 32'd0);
        exp_tx.delete();
        repeat (3) @(negedge clk);
        arst_i = 1'b0;
        repeat (5) @(negedge clk);
        // write after reset, ready immediately
        exp_bus.push_back('{32'h104, 32'h0BADCAFE, 4'hF, 1, 1'b0});
        exp_tx.push_back(8'h06);
        do_write(32'h104, 32'h0BADCAFE);
        wait_idle("wr2");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
